// File: rtl/elbeth_memory_arbiter_if.sv
// ---------------------------------------------------------------------------
// elbeth_memory_arbiter_if
// Bundles the instruction-fetch port, the data-access port and the single
// shared memory port handled by elbeth_memory_arbiter.
//   imem_*  : fetch request (req/addr in, rdata/ready/fault/misaligned out)
//   dmem_*  : data request (req/addr/wdata/rw in, rdata/ready/fault/misaligned out)
//   mem_*   : memory port (enable/addr/wdata/rw out, rdata/ready/error in)
// Modports:
//   slave   : the arbiter's view
//   master  : the environment's view (core requesters plus memory)
// ---------------------------------------------------------------------------
interface elbeth_memory_arbiter_if #(
    parameter int ADDR_BITS = 8
);
    logic                 imem_req;
    logic [31:0]          imem_addr;
    logic [31:0]          imem_rdata;
    logic                 imem_ready;
    logic                 imem_fault;
    logic                 imem_misaligned;

    logic                 dmem_req;
    logic [31:0]          dmem_addr;
    logic [31:0]          dmem_wdata;
    logic [3:0]           dmem_rw;
    logic [31:0]          dmem_rdata;
    logic                 dmem_ready;
    logic                 dmem_fault;
    logic                 dmem_misaligned;

    logic                 mem_enable;
    logic [ADDR_BITS-1:0] mem_addr;
    logic [31:0]          mem_wdata;
    logic [3:0]           mem_rw;
    logic [31:0]          mem_rdata;
    logic                 mem_ready;
    logic                 mem_error;

    modport slave (
        input  imem_req, imem_addr,
        output imem_rdata, imem_ready, imem_fault, imem_misaligned,
        input  dmem_req, dmem_addr, dmem_wdata, dmem_rw,
        output dmem_rdata, dmem_ready, dmem_fault, dmem_misaligned,
        output mem_enable, mem_addr, mem_wdata, mem_rw,
        input  mem_rdata, mem_ready, mem_error
    );

    modport master (
        output imem_req, imem_addr,
        input  imem_rdata, imem_ready, imem_fault, imem_misaligned,
        output dmem_req, dmem_addr, dmem_wdata, dmem_rw,
        input  dmem_rdata, dmem_ready, dmem_fault, dmem_misaligned,
        input  mem_enable, mem_addr, mem_wdata, mem_rw,
        output mem_rdata, mem_ready, mem_error
    );
endinterface

// File: rtl/elbeth_memory_arbiter.sv
// ---------------------------------------------------------------------------
// elbeth_memory_arbiter
// Shares one single-port word memory between the instruction-fetch and the
// data-access requesters. Requests are checked for alignment and range,
// arbitrated with alternating priority, and sequenced through a multi-cycle
// memory access with a ready handshake and a busy timeout. Each requester
// gets a one-cycle registered ready pulse with read data and status flags.
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : elbeth_memory_arbiter_if.slave (imem_*, dmem_*, mem_* groups)
// ---------------------------------------------------------------------------
module elbeth_memory_arbiter #(
    parameter int ADDR_BITS = 8,
    parameter int TIMEOUT   = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    elbeth_memory_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic       GNT_I        = 1'b0;
    localparam logic       GNT_D        = 1'b1;
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    // True when the byte address lies above the memory's byte range.
    function automatic logic addr_out_of_range(input logic [31:0] addr);
        return (addr >> (ADDR_BITS + 2)) != 32'd0;
    endfunction

    state_e               state_q, state_d;
    logic                 last_grant_q, last_grant_d;
    logic                 grant_q, grant_d;
    logic [7:0]           cnt_q, cnt_d;
    logic                 mem_enable_q, mem_enable_d;
    logic [ADDR_BITS-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]          mem_wdata_q, mem_wdata_d;
    logic [3:0]           mem_rw_q, mem_rw_d;
    logic [31:0]          imem_rdata_q, imem_rdata_d;
    logic                 imem_ready_q, imem_ready_d;
    logic                 imem_fault_q, imem_fault_d;
    logic                 imem_mis_q, imem_mis_d;
    logic [31:0]          dmem_rdata_q, dmem_rdata_d;
    logic                 dmem_ready_q, dmem_ready_d;
    logic                 dmem_fault_q, dmem_fault_d;
    logic                 dmem_mis_q, dmem_mis_d;

    logic                 sel_s;
    logic [31:0]          addr_s;
    logic                 resp_valid_s;
    logic                 resp_fault_s;
    logic                 resp_mis_s;
    logic [31:0]          resp_rdata_s;

    // Next-state, memory-port and response computation.
    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        grant_d       = grant_q;
        cnt_d         = cnt_q;
        mem_enable_d  = mem_enable_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        mem_rw_d      = mem_rw_q;
        imem_rdata_d  = imem_rdata_q;
        imem_ready_d  = 1'b0;
        imem_fault_d  = 1'b0;
        imem_mis_d    = 1'b0;
        dmem_rdata_d  = dmem_rdata_q;
        dmem_ready_d  = 1'b0;
        dmem_fault_d  = 1'b0;
        dmem_mis_d    = 1'b0;
        sel_s         = GNT_I;
        addr_s        = 32'd0;
        resp_valid_s  = 1'b0;
        resp_fault_s  = 1'b0;
        resp_mis_s    = 1'b0;
        resp_rdata_s  = 32'd0;

        case (state_q)
            ST_IDLE: begin
                if (bus.imem_req || bus.dmem_req) begin
                    // Data wins when alone, or when fetch was served last.
                    sel_s        = bus.dmem_req && (!bus.imem_req || (last_grant_q == GNT_I));
                    addr_s       = sel_s ? bus.dmem_addr : bus.imem_addr;
                    grant_d      = sel_s;
                    last_grant_d = sel_s;
                    if (addr_s[1:0] != 2'b00) begin
                        resp_valid_s = 1'b1;
                        resp_mis_s   = 1'b1;
                        state_d      = ST_DONE;
                    end else if (addr_out_of_range(addr_s)) begin
                        resp_valid_s = 1'b1;
                        resp_fault_s = 1'b1;
                        state_d      = ST_DONE;
                    end else begin
                        mem_addr_d   = addr_s[ADDR_BITS+1:2];
                        mem_wdata_d  = sel_s ? bus.dmem_wdata : 32'd0;
                        mem_rw_d     = sel_s ? bus.dmem_rw : 4'h0;
                        mem_enable_d = 1'b1;
                        cnt_d        = 8'd0;
                        state_d      = ST_BUSY;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (bus.mem_error) begin
                    resp_valid_s = 1'b1;
                    resp_fault_s = 1'b1;
                end else if (bus.mem_ready) begin
                    resp_valid_s = 1'b1;
                    resp_rdata_s = (mem_rw_q == 4'h0) ? bus.mem_rdata : 32'd0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    resp_valid_s = 1'b1;
                    resp_fault_s = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
                if (resp_valid_s) begin
                    mem_enable_d = 1'b0;
                    mem_rw_d     = 4'h0;
                    state_d      = ST_DONE;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d      = ST_IDLE;
                mem_enable_d = 1'b0;
                mem_rw_d     = 4'h0;
            end
        endcase

        // The response registers load on the edge entering DONE, so the
        // pulse is visible exactly during the DONE cycle.
        if (resp_valid_s) begin
            if (grant_d == GNT_D) begin
                dmem_ready_d = 1'b1;
                dmem_fault_d = resp_fault_s;
                dmem_mis_d   = resp_mis_s;
                dmem_rdata_d = resp_rdata_s;
            end else begin
                imem_ready_d = 1'b1;
                imem_fault_d = resp_fault_s;
                imem_mis_d   = resp_mis_s;
                imem_rdata_d = resp_rdata_s;
            end
        end else begin
            grant_d = grant_d;
        end
    end

    // State and registered-output update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= GNT_D;
            grant_q      <= GNT_I;
            cnt_q        <= 8'd0;
            mem_enable_q <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= 32'd0;
            mem_rw_q     <= 4'h0;
            imem_rdata_q <= 32'd0;
            imem_ready_q <= 1'b0;
            imem_fault_q <= 1'b0;
            imem_mis_q   <= 1'b0;
            dmem_rdata_q <= 32'd0;
            dmem_ready_q <= 1'b0;
            dmem_fault_q <= 1'b0;
            dmem_mis_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            cnt_q        <= cnt_d;
            mem_enable_q <= mem_enable_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_rw_q     <= mem_rw_d;
            imem_rdata_q <= imem_rdata_d;
            imem_ready_q <= imem_ready_d;
            imem_fault_q <= imem_fault_d;
            imem_mis_q   <= imem_mis_d;
            dmem_rdata_q <= dmem_rdata_d;
            dmem_ready_q <= dmem_ready_d;
            dmem_fault_q <= dmem_fault_d;
            dmem_mis_q   <= dmem_mis_d;
        end
    end

    assign bus.mem_enable      = mem_enable_q;
    assign bus.mem_addr        = mem_addr_q;
    assign bus.mem_wdata       = mem_wdata_q;
    assign bus.mem_rw          = mem_rw_q;
    assign bus.imem_rdata      = imem_rdata_q;
    assign bus.imem_ready      = imem_ready_q;
    assign bus.imem_fault      = imem_fault_q;
    assign bus.imem_misaligned = imem_mis_q;
    assign bus.dmem_rdata      = dmem_rdata_q;
    assign bus.dmem_ready      = dmem_ready_q;
    assign bus.dmem_fault      = dmem_fault_q;
    assign bus.dmem_misaligned = dmem_mis_q;

endmodule
